// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NCH valid/ready producers.
// Bursts of up to BURST words per grant; FIFO full stalls a burst without dropping the grant.
//
// state | meaning
// IDLE  | no owner; pick next requester scanning upward from last_q+1
// GRANT | grant_q owns the write port until burst end or its valid drops
module fifo_wr_arbiter #(
  parameter int NCH   = 4,
  parameter int DW    = 12,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DW-1:0]     fifo_data,
  output logic [NCH-1:0]    grant,
  output logic              busy
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [CW-1:0]  beat_q, beat_d;
  logic [IW-1:0]  last_q, last_d;

  logic [IW-1:0]  owner;
  logic [IW-1:0]  pick;
  logic           found;
  int             idx;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_q[i]) owner = IW'(i);
    end

    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_q) + k) % NCH;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end

    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    if (state_q == GRANT) begin
      fifo_data = req_data[int'(owner)*DW +: DW];
      // Nothing moves while reset is asserted, so an abandoned burst never writes.
      if (rst_n && !fifo_full) begin
        req_ready  = grant_q;
        fifo_wr_en = req_valid[owner];
      end
    end

    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = NCH'(1) << pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_valid[owner] || (fifo_wr_en && beat_q == CW'(BURST - 1))) begin
          last_d  = owner;
          grant_d = '0;
          state_d = IDLE;
        end else if (fifo_wr_en) begin
          beat_d = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      beat_q  <= '0;
      last_q  <= IW'(NCH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

endmodule
